// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage RV32I pipeline: load-use stall sequencer, dmem-wait freeze, branch flush.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush event counters.
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [REG_ADDR_W-1:0] i_ex_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_ex_rs2_addr,
  input  logic                  i_ex_rs1_used,
  input  logic                  i_ex_rs2_used,
  input  logic                  i_ex_branch_taken,
  input  logic [REG_ADDR_W-1:0] i_mem_rd_addr,
  input  logic                  i_mem_is_load,
  input  logic                  i_mem_rd_wren,
  input  logic                  i_dmem_ready,
  output logic                  o_pc_stall,
  output logic                  o_if_id_stall,
  output logic                  o_id_ex_stall,
  output logic                  o_ex_mem_stall,
  output logic                  o_if_id_flush,
  output logic                  o_id_ex_flush,
  output logic                  o_ex_mem_flush,
  output logic                  o_lu_busy,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  typedef enum logic {IDLE = 1'b0, LU_STALL = 1'b1} state_t;

  // The first stall cycle is issued from IDLE, so LU_STALL covers the remaining ones.
  localparam logic [3:0] LOAD_CNT = 4'(LOAD_STALL_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu_hit;
  logic       mem_wait;
  logic       lu_stall_act;

  assign lu_hit = i_mem_rd_wren & i_mem_is_load & (i_mem_rd_addr != '0) &
                  ((i_ex_rs1_used & (i_ex_rs1_addr == i_mem_rd_addr)) |
                   (i_ex_rs2_used & (i_ex_rs2_addr == i_mem_rd_addr)));
  assign mem_wait     = ~i_dmem_ready;
  assign lu_stall_act = (state_q == LU_STALL) | lu_hit;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_wait) begin
      case (state_q)
        IDLE: begin
          if (lu_hit && (LOAD_STALL_CYCLES > 1)) begin
            state_d = LU_STALL;
            cnt_d   = LOAD_CNT;
          end
        end
        LU_STALL: begin
          if (cnt_q <= 4'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Priority: reset, then memory wait, then load-use stall, then branch flush.
  always_comb begin
    o_pc_stall     = 1'b0;
    o_if_id_stall  = 1'b0;
    o_id_ex_stall  = 1'b0;
    o_ex_mem_stall = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_flush = 1'b0;
    o_lu_busy      = 1'b0;
    if (i_reset) begin
      o_lu_busy = (state_q == LU_STALL);
      if (mem_wait) begin
        o_pc_stall     = 1'b1;
        o_if_id_stall  = 1'b1;
        o_id_ex_stall  = 1'b1;
        o_ex_mem_stall = 1'b1;
      end else if (lu_stall_act) begin
        o_pc_stall     = 1'b1;
        o_if_id_stall  = 1'b1;
        o_id_ex_stall  = 1'b1;
        o_ex_mem_flush = 1'b1;
      end else if (i_ex_branch_taken) begin
        o_if_id_flush = 1'b1;
        o_id_ex_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (o_pc_stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (o_if_id_flush && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: one instance with a 3-cycle load-use stall, one with a 1-cycle stall.
// Output vector order: {pc_s, if_id_s, id_ex_s, ex_mem_s, if_id_f, id_ex_f, ex_mem_f, lu_busy}.
module tb_hazard_ctrl_unit;

  localparam int AW = 5;
  localparam int CW = 4;

  localparam logic [7:0] Z  = 8'h00; // nothing asserted
  localparam logic [7:0] LU = 8'hE2; // load-use stall set from IDLE
  localparam logic [7:0] LB = 8'hE3; // load-use stall set while busy
  localparam logic [7:0] BR = 8'h0C; // branch flush
  localparam logic [7:0] MW = 8'hF0; // memory wait, idle
  localparam logic [7:0] MB = 8'hF1; // memory wait, busy

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [AW-1:0] rs1, rs2, rd;
  logic          u1, u2, br, ld, wr, rdy;

  logic          pc3, ifs3, ids3, exs3, iff3, idf3, exf3, busy3;
  logic          pc1, ifs1, ids1, exs1, iff1, idf1, exf1, busy1;
  logic [CW-1:0] sc3, fc3, sc1, fc1;

  logic [CW-1:0] exp_sc3, exp_fc3, exp_sc1, exp_fc1;
  int            errors = 0;
  int            checks = 0;

  typedef struct {
    string      tag;
    logic [7:0] e3;
    logic [7:0] e1;
  } exp_t;
  exp_t sb[$];

  always #5 i_clk = ~i_clk;

  hazard_ctrl_unit #(.REG_ADDR_W(AW), .LOAD_STALL_CYCLES(3), .CNT_W(CW)) u_dut3 (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_ex_rs1_addr(rs1), .i_ex_rs2_addr(rs2), .i_ex_rs1_used(u1), .i_ex_rs2_used(u2),
    .i_ex_branch_taken(br), .i_mem_rd_addr(rd), .i_mem_is_load(ld), .i_mem_rd_wren(wr),
    .i_dmem_ready(rdy),
    .o_pc_stall(pc3), .o_if_id_stall(ifs3), .o_id_ex_stall(ids3), .o_ex_mem_stall(exs3),
    .o_if_id_flush(iff3), .o_id_ex_flush(idf3), .o_ex_mem_flush(exf3), .o_lu_busy(busy3),
    .o_stall_cnt(sc3), .o_flush_cnt(fc3)
  );

  hazard_ctrl_unit #(.REG_ADDR_W(AW), .LOAD_STALL_CYCLES(1), .CNT_W(CW)) u_dut1 (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_ex_rs1_addr(rs1), .i_ex_rs2_addr(rs2), .i_ex_rs1_used(u1), .i_ex_rs2_used(u2),
    .i_ex_branch_taken(br), .i_mem_rd_addr(rd), .i_mem_is_load(ld), .i_mem_rd_wren(wr),
    .i_dmem_ready(rdy),
    .o_pc_stall(pc1), .o_if_id_stall(ifs1), .o_id_ex_stall(ids1), .o_ex_mem_stall(exs1),
    .o_if_id_flush(iff1), .o_id_ex_flush(idf1), .o_ex_mem_flush(exf1), .o_lu_busy(busy1),
    .o_stall_cnt(sc1), .o_flush_cnt(fc1)
  );

  task automatic set_in(input logic [AW-1:0] a1, input logic b1, input logic [AW-1:0] a2,
                        input logic b2, input logic [AW-1:0] ad, input logic l, input logic w,
                        input logic b, input logic r);
    rs1 = a1; u1 = b1; rs2 = a2; u2 = b2; rd = ad; ld = l; wr = w; br = b; rdy = r;
  endtask

  task automatic idle_in();
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // lw x5 in MEM, EX reads x5 on rs1
  task automatic hazard_in();
    set_in(5'd5, 1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, want);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] e3, input logic [7:0] e1);
    exp_t e;
    logic [7:0] o3, o1;
    e.tag = tag; e.e3 = e3; e.e1 = e1;
    sb.push_back(e);
    #2;
    e  = sb.pop_front();
    o3 = {pc3, ifs3, ids3, exs3, iff3, idf3, exf3, busy3};
    o1 = {pc1, ifs1, ids1, exs1, iff1, idf1, exf1, busy1};
    checks++;
    assert (o3 === e.e3) else begin
      errors++;
      $error("FAIL %s lsc3 got=%h exp=%h", e.tag, o3, e.e3);
    end
    checks++;
    assert (o1 === e.e1) else begin
      errors++;
      $error("FAIL %s lsc1 got=%h exp=%h", e.tag, o1, e.e1);
    end
    chk_cnt({e.tag, " stall_cnt3"}, sc3, exp_sc3);
    chk_cnt({e.tag, " flush_cnt3"}, fc3, exp_fc3);
    chk_cnt({e.tag, " stall_cnt1"}, sc1, exp_sc1);
    chk_cnt({e.tag, " flush_cnt1"}, fc1, exp_fc1);
`ifdef HAZARD_PERF_CNT_EN
    if (i_reset) begin
      if (e.e3[7] && exp_sc3 != 4'hF) exp_sc3++;
      if (e.e3[3] && exp_fc3 != 4'hF) exp_fc3++;
      if (e.e1[7] && exp_sc1 != 4'hF) exp_sc1++;
      if (e.e1[3] && exp_fc1 != 4'hF) exp_fc1++;
    end
`endif
    @(negedge i_clk);
  endtask

  task automatic clear_model();
    exp_sc3 = '0; exp_fc3 = '0; exp_sc1 = '0; exp_fc1 = '0;
  endtask

  initial begin
    clear_model();
    i_reset = 1'b0;
    hazard_in();
    chk("reset_gates_hazard", Z, Z);
    i_reset = 1'b1;
    idle_in();
    chk("after_reset_idle", Z, Z);

    // single load-use event
    hazard_in();
    chk("lu_c1", LU, LU);
    idle_in();
    chk("lu_c2", LB, Z);
    chk("lu_c3", LB, Z);
    chk("lu_c4_idle", Z, Z);

    // no-hazard corner cases, then rs2 hit
    set_in(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rd_x0", Z, Z);
    set_in(5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rs2_unused", Z, Z);
    set_in(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("no_wren", Z, Z);
    set_in(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("not_load", Z, Z);
    set_in(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("rs2_hit", LU, LU);
    idle_in();
    chk("rs2_c2", LB, Z);
    chk("rs2_c3", LB, Z);

    // branch handling
    idle_in(); br = 1'b1;
    chk("branch", BR, BR);
    br = 1'b0;
    chk("branch_off", Z, Z);
    hazard_in(); br = 1'b1;
    chk("branch_and_lu", LU, LU);
    idle_in(); br = 1'b1;
    chk("branch_under_stall_c2", LB, BR);
    chk("branch_under_stall_c3", LB, BR);
    chk("branch_released", BR, BR);
    br = 1'b0;
    chk("branch_clear", Z, Z);

    // memory wait in the middle of LU_STALL
    hazard_in();
    chk("mw_lu_c1", LU, LU);
    idle_in(); rdy = 1'b0;
    chk("mw_wait1", MB, MW);
    chk("mw_wait2", MB, MW);
    rdy = 1'b1;
    chk("mw_lu_c2", LB, Z);
    chk("mw_lu_c3", LB, Z);
    chk("mw_done", Z, Z);

    // memory wait overrides a hazard plus branch in IDLE
    hazard_in(); br = 1'b1; rdy = 1'b0;
    chk("mw_over_all", MW, MW);
    rdy = 1'b1;
    chk("mw_release_lu", LU, LU);
    idle_in();
    chk("mw_rel_c2", LB, Z);
    chk("mw_rel_c3", LB, Z);
    chk("mw_rel_idle", Z, Z);

    // reset aborts LU_STALL
    hazard_in();
    chk("rst_lu_c1", LU, LU);
    idle_in();
    chk("rst_lu_c2", LB, Z);
    i_reset = 1'b0;
    clear_model();
    chk("rst_mid_stall", Z, Z);
    i_reset = 1'b1;
    chk("rst_released_idle", Z, Z);
    hazard_in();
    chk("post_rst_lu_c1", LU, LU);
    idle_in();
    chk("post_rst_c2", LB, Z);
    chk("post_rst_c3", LB, Z);
    chk("post_rst_idle", Z, Z);

    // 20 stall cycles to saturate the stall counter
    idle_in(); rdy = 1'b0;
    for (int i = 0; i < 20; i++) chk("sat_wait", MW, MW);
    rdy = 1'b1;
    chk("sat_end", Z, Z);
`ifdef HAZARD_PERF_CNT_EN
    chk_cnt("stall_cnt_saturated", sc3, 4'hF);
    chk_cnt("stall_cnt1_saturated", sc1, 4'hF);
`else
    chk_cnt("stall_cnt_tied_off", sc3, 4'h0);
    chk_cnt("flush_cnt_tied_off", fc1, 4'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the pipeline hazard detection unit of the 5-stage RV32I core. Combines load-use detection with a configurable multi-cycle load-use stall sequencer, a data-memory wait freeze and branch-flush generation. Drives stall and flush enables for the PC, IF/ID, ID/EX and EX/MEM registers. Optionally keeps saturating stall and flush event counters for performance analysis.

Parameters:
REG_ADDR_W, 5, register address width.
LOAD_STALL_CYCLES, 1, stall cycles per load-use event; legal range 1..15.
CNT_W, 32, width of the performance counters.

Ports:
i_clk  in  1  core clock, rising edge.
i_reset  in  1  asynchronous, active-low reset.
i_ex_rs1_addr  in  REG_ADDR_W  rs1 of the instruction in EX.
i_ex_rs2_addr  in  REG_ADDR_W  rs2 of the instruction in EX.
i_ex_rs1_used  in  1  EX instruction reads rs1.
i_ex_rs2_used  in  1  EX instruction reads rs2.
i_ex_branch_taken  in  1  redirect (taken branch or jump) resolved in EX.
i_mem_rd_addr  in  REG_ADDR_W  rd of the instruction in MEM.
i_mem_is_load  in  1  MEM instruction is a load.
i_mem_rd_wren  in  1  MEM instruction writes rd.
i_dmem_ready  in  1  data memory done; 0 freezes the pipeline.
o_pc_stall  out  1  hold PC.
o_if_id_stall  out  1  hold IF/ID.
o_id_ex_stall  out  1  hold ID/EX.
o_ex_mem_stall  out  1  hold EX/MEM (memory wait only).
o_if_id_flush  out  1  clear IF/ID.
o_id_ex_flush  out  1  clear ID/EX.
o_ex_mem_flush  out  1  insert a bubble into EX/MEM.
o_lu_busy  out  1  FSM is in LU_STALL.
o_stall_cnt  out  CNT_W  stall-cycle counter.
o_flush_cnt  out  CNT_W  flush-event counter.

Behaviour:
- lu_hit (combinational) = i_mem_rd_wren & i_mem_is_load & (i_mem_rd_addr != 0) & ((i_ex_rs1_used & rs1 == rd) | (i_ex_rs2_used & rs2 == rd)).
- mem_wait = ~i_dmem_ready. It overrides everything: pc, IF/ID, ID/EX and EX/MEM stalls are 1; all flushes are 0; FSM state and counter are frozen.
- FSM states:
  - IDLE: outputs are driven from lu_hit. If lu_hit and LOAD_STALL_CYCLES > 1 (and no mem_wait), load cnt = LOAD_STALL_CYCLES-1 and go to LU_STALL.
  - LU_STALL: assert the load-use stall set regardless of lu_hit. Decrement cnt each non-wait cycle. At cnt == 1, go to IDLE at the next edge.
- Load-use stall set: o_pc_stall = o_if_id_stall = o_id_ex_stall = o_ex_mem_flush = 1; o_ex_mem_stall = 0.
- Total stall cycles per event = exactly LOAD_STALL_CYCLES: the first cycle comes from IDLE, the rest from LU_STALL. LOAD_STALL_CYCLES = 1 never enters LU_STALL.
- Branch: o_if_id_flush = o_id_ex_flush = i_ex_branch_taken & ~(load-use stall active) & ~mem_wait. A taken branch under a stall is suppressed; the branch re-resolves when EX releases.
- Simultaneous lu_hit and branch: stall wins, no flush.
- Reset (async, i_reset = 0): state = IDLE, cnt = 0, counters = 0, every output = 0 while reset is asserted. Reset mid-LU_STALL aborts the sequence. Deassertion is synchronised by the surrounding reset tree.
- Stall/flush outputs are combinational from inputs and state (zero latency). State and counters are registered.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: o_stall_cnt increments on each cycle with o_pc_stall = 1; o_flush_cnt increments on each cycle with o_if_id_flush = 1. Both saturate at all-ones (no wrap).
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
1. LOAD_STALL_CYCLES = 1; MEM lw x5, EX add rs1 = x5 (used) -> one cycle with pc/if_id/id_ex stall = 1 and ex_mem_flush = 1; o_lu_busy stays 0.
2. LOAD_STALL_CYCLES = 3; same hazard -> stall set held for exactly 3 cycles; o_lu_busy = 1 in cycles 2–3; IDLE on cycle 4.
3. MEM rd = x0 load, or rs2 matches but i_ex_rs2_used = 0 -> no stall, no flush.
4. i_ex_branch_taken = 1, no hazard -> if_id_flush = id_ex_flush = 1 for one cycle. Same cycle with lu_hit -> flushes 0, stall set 1.
5. LOAD_STALL_CYCLES = 3; i_dmem_ready = 0 for 2 cycles mid-LU_STALL -> all four stalls = 1, flushes 0, cnt frozen; LU_STALL resumes and totals 3 non-wait stall cycles.
6. i_reset = 0 during LU_STALL -> outputs 0 immediately; after release, state is IDLE. With HAZARD_PERF_CNT_EN and CNT_W = 4, 20 stall cycles -> o_stall_cnt = 15.
